bp_be_irf_wb_arbiter: RTL and testbench
=======================================

// Module: bp_be_irf_wb_arbiter
// PURPOSE
//  Shares the single integer-regfile write port among three writers:
//    - in-order pipeline writeback (cannot be back-pressured)
//    - cfg-bus debug writes
//    - long-latency writeback (div/mul/fp->int; valid/ready)
//  Keeps a scoreboard of long-latency destinations that are still pending, so issue can stall on RAW hazards.
//  Sits between the calculator writeback stage and bp_be_int_regfile's rd write bus.
// PARAMETERS
//  bp_params_p     e_bp_inv_cfg  processor config; supplies reg_addr_width_p (5) and dword_width_p (64)
//  starve_limit_p  8             consecutive blocked long-latency cycles before stall_o asserts
// PORTS
//  clk_i           in   1      clock
//  reset_i         in   1      reset: synchronous, active-high
//  pipe_w_v_i      in   1      pipeline writeback valid; always accepted
//  pipe_addr_i     in   5      pipeline rd
//  pipe_data_i     in   64     pipeline rd data
//  cfg_w_v_i       in   1      cfg write request
//  cfg_addr_i      in   5      cfg write address
//  cfg_data_i      in   64     cfg write data
//  cfg_ready_o     out  1      cfg write accepted this cycle
//  ll_issue_v_i    in   1      long-latency op issued; sets the scoreboard bit
//  ll_issue_rd_i   in   5      long-latency destination register
//  ll_v_i          in   1      long-latency result valid
//  ll_addr_i       in   5      long-latency rd
//  ll_data_i       in   64     long-latency data
//  ll_ready_and_o  out  1      long-latency result consumed (valid & ready handshake)
//  rs1_addr_i      in   5      issue-stage source address 1
//  rs2_addr_i      in   5      issue-stage source address 2
//  rs1_busy_o      out  1      scoreboard bit for rs1 (0 when address is x0)
//  rs2_busy_o      out  1      scoreboard bit for rs2 (0 when address is x0)
//  stall_o         out  1      starvation hold request to the issue stage
//  rd_w_v_o        out  1      to regfile rd_w_v_i
//  rd_addr_o       out  5      to regfile rd_addr_i
//  rd_data_o       out  64     to regfile rd_data_i
// BEHAVIOUR
//  - Priority: pipe > cfg > ll. The write-port mux is combinational; write latency is 0 cycles.
//  - cfg_ready_o = ~pipe_w_v_i.
//  - Base (no skid): ll_ready_and_o = ~pipe_w_v_i & ~cfg_w_v_i.
//  - Writes to x0: a write with addr 0 drives rd_w_v_o=0 but is still handshaken (cfg_ready_o / ll_ready_and_o as normal).
//  - Scoreboard: 32 flops.
//    - Set on ll_issue_v_i at ll_issue_rd_i (x0 is never set).
//    - Cleared when ll_addr_i is handshaken.
//    - Set and clear to the same address in one cycle: the bit stays 1 (the newer op owns it).
//  - Issuing to a register whose bit is already set is illegal; flagged by an assertion.
//  - Starvation counter:
//    - Increments while ll_v_i & ~ll_ready_and_o, saturating at starve_limit_p.
//    - Cleared on an ll handshake or when ll_v_i=0.
//    - stall_o = (count == starve_limit_p), registered; it deasserts the cycle after the ll handshake.
//  - Reset: scoreboard=0, counter=0, stall_o=0, skid empty.
//    - Outputs during reset: rd_w_v_o=0, ll_ready_and_o=0, cfg_ready_o=0.
//    - Reset mid-operation discards any buffered entry.
// CONFIGURATION
//  Macro BP_BE_IRF_WB_SKID_EN.
//  - Defined: one-entry skid buffer (addr+data) on the ll path.
//    - ll_ready_and_o = skid empty, independent of pipe/cfg.
//    - The skid drains at lowest priority.
//    - The scoreboard clears when the skid writes the regfile, not when it is loaded.
//    - Starvation counts skid-occupied blocked cycles.
//  - Undefined: the ll path is combinational as described above; no extra state.
// STRUCTURE
//  - Shared package bp_be_pkg: writer-select enum e_wb_src_pipe/e_wb_src_cfg/e_wb_src_ll.
//  - rs1/rs2 lookups read the scoreboard vector directly.
//  - One natural sub-module, bp_be_irf_scoreboard: set/clear/lookup for 32 bits.
// TESTING
//  1. pipe_w_v_i=1 (r5,0xA), cfg_w_v_i=1 (r6), ll_v_i=1 (r7) same cycle
//     -> rd=r5/0xA, cfg_ready_o=0, ll_ready_and_o=0; next cycle with pipe idle -> cfg r6 written.
//  2. ll_issue r9 -> rs1_addr_i=9 gives rs1_busy_o=1; ll handshake r9 -> busy clears the following cycle.
//  3. Issue r3 while ll retires r3 in the same cycle -> bit remains 1.
//  4. ll_v_i held with pipe_w_v_i=1 for 8 cycles -> stall_o=1 on cycle 9.
//     Pipe idles -> ll written; stall_o=0 the next cycle.
//  5. ll write to x0 -> ll_ready_and_o=1, rd_w_v_o=0, scoreboard unchanged.
//  6. reset_i asserted with skid full and scoreboard non-zero (SKID_EN)
//     -> all bits 0, skid empty, no write issued after reset.

Source files
------------

// File: rtl/bp_be_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bp_be_pkg
// Description : Shared backend types: processor config selector, regfile
//               geometry helpers and the writeback-source select enum.
// Revision    : 1.0 - initial release
// ============================================================================
package bp_be_pkg;

    typedef enum logic [0:0] {
        e_bp_inv_cfg = 1'b0
    } bp_params_e;

    typedef enum logic [1:0] {
        e_wb_src_pipe = 2'd0,
        e_wb_src_cfg  = 2'd1,
        e_wb_src_ll   = 2'd2
    } wb_src_e;

    localparam int c_NUM_REGS = 32;

    function automatic int reg_addr_width(input bp_params_e cfg);
        case (cfg)
            e_bp_inv_cfg: return 5;
            default:      return 5;
        endcase
    endfunction

    function automatic int dword_width(input bp_params_e cfg);
        case (cfg)
            e_bp_inv_cfg: return 64;
            default:      return 64;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/bp_be_irf_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : bp_be_irf_scoreboard
// Description : 32-entry pending-write scoreboard for long-latency ops with
//               two combinational source lookups. x0 is never marked busy.
// Revision    : 1.0 - initial release
// ============================================================================
module bp_be_irf_scoreboard
    import bp_be_pkg::*;
(
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       set_v_i,
    input  logic [4:0] set_addr_i,
    input  logic       clr_v_i,
    input  logic [4:0] clr_addr_i,
    input  logic [4:0] rs1_addr_i,
    input  logic [4:0] rs2_addr_i,
    output logic       rs1_busy_o,
    output logic       rs2_busy_o
);

    logic [c_NUM_REGS-1:0] busy_q;
    logic [c_NUM_REGS-1:0] busy_d;

    // Set is applied after clear so a same-cycle reissue keeps the bit owned.
    always_comb begin
        busy_d = busy_q;
        if (clr_v_i) begin
            busy_d[clr_addr_i] = 1'b0;
        end
        if (set_v_i && (set_addr_i != 5'd0)) begin
            busy_d[set_addr_i] = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i && set_v_i && (set_addr_i != 5'd0)) begin
            assert (!busy_q[set_addr_i] || (clr_v_i && (clr_addr_i == set_addr_i)));
        end
    end

    assign rs1_busy_o = busy_q[rs1_addr_i] & (rs1_addr_i != 5'd0);
    assign rs2_busy_o = busy_q[rs2_addr_i] & (rs2_addr_i != 5'd0);

endmodule
`default_nettype wire

// File: rtl/bp_be_irf_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : bp_be_irf_wb_arbiter
// Description : Integer regfile write-port arbiter (pipe > cfg > ll) with a
//               long-latency scoreboard and starvation stall. Defining
//               BP_BE_IRF_WB_SKID_EN adds a one-entry skid on the ll path.
// Revision    : 1.0 - initial release
// ============================================================================
module bp_be_irf_wb_arbiter
    import bp_be_pkg::*;
#(
    parameter bp_params_e bp_params_p    = e_bp_inv_cfg,
    parameter int         starve_limit_p = 8
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        pipe_w_v_i,
    input  logic [4:0]  pipe_addr_i,
    input  logic [63:0] pipe_data_i,
    input  logic        cfg_w_v_i,
    input  logic [4:0]  cfg_addr_i,
    input  logic [63:0] cfg_data_i,
    output logic        cfg_ready_o,
    input  logic        ll_issue_v_i,
    input  logic [4:0]  ll_issue_rd_i,
    input  logic        ll_v_i,
    input  logic [4:0]  ll_addr_i,
    input  logic [63:0] ll_data_i,
    output logic        ll_ready_and_o,
    input  logic [4:0]  rs1_addr_i,
    input  logic [4:0]  rs2_addr_i,
    output logic        rs1_busy_o,
    output logic        rs2_busy_o,
    output logic        stall_o,
    output logic        rd_w_v_o,
    output logic [4:0]  rd_addr_o,
    output logic [63:0] rd_data_o
);

    localparam int c_AW = reg_addr_width(bp_params_p);
    localparam int c_DW = dword_width(bp_params_p);
    localparam int c_CW = $clog2(starve_limit_p + 1);
    localparam logic [c_CW-1:0] c_STARVE_LIMIT = c_CW'(starve_limit_p);

    wb_src_e         src;
    logic            src_v;
    logic            ll_hs;
    logic            ll_src_v;
    logic [c_AW-1:0] ll_src_addr;
    logic [c_DW-1:0] ll_src_data;
    logic            clr_v;
    logic [c_AW-1:0] clr_addr;
    logic            blocked;
    logic [c_CW-1:0] starve_cnt_q;
    logic [c_CW-1:0] starve_cnt_d;

    assign cfg_ready_o = ~reset_i & ~pipe_w_v_i;
    assign ll_hs       = ll_v_i & ll_ready_and_o;

`ifdef BP_BE_IRF_WB_SKID_EN
    logic            skid_v_q;
    logic            skid_v_d;
    logic [c_AW-1:0] skid_addr_q;
    logic [c_AW-1:0] skid_addr_d;
    logic [c_DW-1:0] skid_data_q;
    logic [c_DW-1:0] skid_data_d;
    logic            skid_drain;

    assign ll_ready_and_o = ~reset_i & ~skid_v_q;
    assign ll_src_v       = skid_v_q;
    assign ll_src_addr    = skid_addr_q;
    assign ll_src_data    = skid_data_q;
    assign skid_drain     = src_v & (src == e_wb_src_ll);
    // The pending bit belongs to the op until its data actually lands.
    assign clr_v          = skid_drain;
    assign clr_addr       = skid_addr_q;
    assign blocked        = skid_v_q & ~skid_drain;

    always_comb begin
        skid_v_d    = skid_v_q;
        skid_addr_d = skid_addr_q;
        skid_data_d = skid_data_q;
        if (skid_drain) begin
            skid_v_d = 1'b0;
        end
        if (ll_hs) begin
            skid_v_d    = 1'b1;
            skid_addr_d = ll_addr_i;
            skid_data_d = ll_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            skid_v_q    <= 1'b0;
            skid_addr_q <= '0;
            skid_data_q <= '0;
        end else begin
            skid_v_q    <= skid_v_d;
            skid_addr_q <= skid_addr_d;
            skid_data_q <= skid_data_d;
        end
    end
`else
    assign ll_ready_and_o = ~reset_i & ~pipe_w_v_i & ~cfg_w_v_i;
    assign ll_src_v       = ll_v_i;
    assign ll_src_addr    = ll_addr_i;
    assign ll_src_data    = ll_data_i;
    assign clr_v          = ll_hs;
    assign clr_addr       = ll_addr_i;
    assign blocked        = ll_v_i & ~ll_ready_and_o;
`endif

    always_comb begin
        src   = e_wb_src_pipe;
        src_v = 1'b0;
        if (pipe_w_v_i) begin
            src   = e_wb_src_pipe;
            src_v = 1'b1;
        end else if (cfg_w_v_i) begin
            src   = e_wb_src_cfg;
            src_v = 1'b1;
        end else if (ll_src_v) begin
            src   = e_wb_src_ll;
            src_v = 1'b1;
        end
    end

    always_comb begin
        rd_addr_o = pipe_addr_i;
        rd_data_o = pipe_data_i;
        case (src)
            e_wb_src_cfg: begin
                rd_addr_o = cfg_addr_i;
                rd_data_o = cfg_data_i;
            end
            e_wb_src_ll: begin
                rd_addr_o = ll_src_addr;
                rd_data_o = ll_src_data;
            end
            default: ;
        endcase
    end

    // x0 writes still win arbitration and handshake, they just never reach the regfile.
    assign rd_w_v_o = ~reset_i & src_v & (rd_addr_o != 5'd0);

    always_comb begin
        starve_cnt_d = '0;
        if (blocked) begin
            starve_cnt_d = (starve_cnt_q == c_STARVE_LIMIT) ? starve_cnt_q
                                                            : starve_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

    assign stall_o = (starve_cnt_q == c_STARVE_LIMIT);

    bp_be_irf_scoreboard u_scoreboard (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .set_v_i    (ll_issue_v_i),
        .set_addr_i (ll_issue_rd_i),
        .clr_v_i    (clr_v),
        .clr_addr_i (clr_addr),
        .rs1_addr_i (rs1_addr_i),
        .rs2_addr_i (rs2_addr_i),
        .rs1_busy_o (rs1_busy_o),
        .rs2_busy_o (rs2_busy_o)
    );

endmodule
`default_nettype wire

// File: tb/tb_bp_be_irf_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_bp_be_irf_wb_arbiter
// Description : Self-checking bench: vector table, directed corner sequences
//               and randomized traffic against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bp_be_irf_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        pipe_v;
    logic [4:0]  pipe_a;
    logic [63:0] pipe_d;
    logic        cfg_v;
    logic [4:0]  cfg_a;
    logic [63:0] cfg_d;
    logic        cfg_ready;
    logic        iss_v;
    logic [4:0]  iss_rd;
    logic        ll_v;
    logic [4:0]  ll_a;
    logic [63:0] ll_d;
    logic        ll_rdy;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        rs1_busy;
    logic        rs2_busy;
    logic        stall;
    logic        rd_w_v;
    logic [4:0]  rd_a;
    logic [63:0] rd_d;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    bp_be_irf_wb_arbiter dut (
        .clk_i          (clk),
        .reset_i        (rst),
        .pipe_w_v_i     (pipe_v),
        .pipe_addr_i    (pipe_a),
        .pipe_data_i    (pipe_d),
        .cfg_w_v_i      (cfg_v),
        .cfg_addr_i     (cfg_a),
        .cfg_data_i     (cfg_d),
        .cfg_ready_o    (cfg_ready),
        .ll_issue_v_i   (iss_v),
        .ll_issue_rd_i  (iss_rd),
        .ll_v_i         (ll_v),
        .ll_addr_i      (ll_a),
        .ll_data_i      (ll_d),
        .ll_ready_and_o (ll_rdy),
        .rs1_addr_i     (rs1),
        .rs2_addr_i     (rs2),
        .rs1_busy_o     (rs1_busy),
        .rs2_busy_o     (rs2_busy),
        .stall_o        (stall),
        .rd_w_v_o       (rd_w_v),
        .rd_addr_o      (rd_a),
        .rd_data_o      (rd_d)
    );

    // Reference model: pending set, starvation count, skid as a FIFO of results.
    typedef struct {
        logic [4:0]  a;
        logic [63:0] d;
    } ent_t;

    bit [31:0]   m_sb;
    int          m_cnt;
    ent_t        m_skq[$];
    bit          e_cfg_rdy, e_ll_rdy, e_w, e_src_v, e_drain;
    logic [4:0]  e_a;
    logic [63:0] e_d;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_eval();
        e_cfg_rdy = !rst && !pipe_v;
`ifdef BP_BE_IRF_WB_SKID_EN
        e_ll_rdy = !rst && (m_skq.size() == 0);
`else
        e_ll_rdy = !rst && !pipe_v && !cfg_v;
`endif
        e_src_v = 1'b0;
        e_drain = 1'b0;
        e_a     = '0;
        e_d     = '0;
        if (pipe_v) begin
            e_src_v = 1'b1; e_a = pipe_a; e_d = pipe_d;
        end else if (cfg_v) begin
            e_src_v = 1'b1; e_a = cfg_a; e_d = cfg_d;
        end
`ifdef BP_BE_IRF_WB_SKID_EN
        else if (m_skq.size() != 0) begin
            e_src_v = 1'b1; e_a = m_skq[0].a; e_d = m_skq[0].d; e_drain = 1'b1;
        end
`else
        else if (ll_v) begin
            e_src_v = 1'b1; e_a = ll_a; e_d = ll_d;
        end
`endif
        e_w = !rst && e_src_v && (e_a != 5'd0);
    endtask

    task automatic model_update();
        bit hs;
        bit blocked;
        if (rst) begin
            m_sb  = '0;
            m_cnt = 0;
            m_skq.delete();
            return;
        end
        hs = ll_v && e_ll_rdy;
`ifdef BP_BE_IRF_WB_SKID_EN
        blocked = (m_skq.size() != 0) && !e_drain;
        if (e_drain) begin
            m_sb[m_skq[0].a] = 1'b0;
            void'(m_skq.pop_front());
        end
        if (hs) m_skq.push_back('{ll_a, ll_d});
`else
        blocked = ll_v && !hs;
        if (hs) m_sb[ll_a] = 1'b0;
`endif
        if (iss_v && (iss_rd != 5'd0)) m_sb[iss_rd] = 1'b1;
        m_cnt = blocked ? ((m_cnt < 8) ? m_cnt + 1 : 8) : 0;
    endtask

    task automatic check_now();
        #2;
        model_eval();
        chk("cfg_ready", {63'd0, cfg_ready}, {63'd0, e_cfg_rdy});
        chk("ll_ready", {63'd0, ll_rdy}, {63'd0, e_ll_rdy});
        chk("rd_w_v", {63'd0, rd_w_v}, {63'd0, e_w});
        if (e_w) begin
            chk("rd_addr", {59'd0, rd_a}, {59'd0, e_a});
            chk("rd_data", rd_d, e_d);
        end
        if (!rst) begin
            chk("rs1_busy", {63'd0, rs1_busy}, {63'd0, m_sb[rs1] && (rs1 != 5'd0)});
            chk("rs2_busy", {63'd0, rs2_busy}, {63'd0, m_sb[rs2] && (rs2 != 5'd0)});
            chk("stall", {63'd0, stall}, {63'd0, m_cnt == 8});
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle_inputs();
        pipe_v = 1'b0; pipe_a = '0; pipe_d = '0;
        cfg_v  = 1'b0; cfg_a  = '0; cfg_d  = '0;
        ll_v   = 1'b0; ll_a   = '0; ll_d   = '0;
        iss_v  = 1'b0; iss_rd = '0;
    endtask

    typedef struct {
        logic        pv;
        logic [4:0]  pa;
        logic [63:0] pd;
        logic        cv;
        logic [4:0]  ca;
        logic [63:0] cd;
        logic        lv;
        logic [4:0]  la;
        logic [63:0] ld;
        logic        ew;
        logic [4:0]  ea;
        logic [63:0] ed;
        logic        ecr;
        logic        elr;
    } vec_t;

    vec_t tbl[7];

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{1'b1, 5'd5, 64'hA, 1'b1, 5'd6, 64'h66, 1'b1, 5'd7, 64'h77, 1'b1, 5'd5, 64'hA,  1'b0, 1'b0};
        tbl[1] = '{1'b0, 5'd0, 64'h0, 1'b1, 5'd6, 64'h66, 1'b1, 5'd7, 64'h77, 1'b1, 5'd6, 64'h66, 1'b1, 1'b0};
        tbl[2] = '{1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0,  1'b1, 5'd7, 64'h77, 1'b1, 5'd7, 64'h77, 1'b1, 1'b1};
        tbl[3] = '{1'b1, 5'd0, 64'h5, 1'b1, 5'd6, 64'h66, 1'b0, 5'd0, 64'h0,  1'b0, 5'd0, 64'h0,  1'b0, 1'b0};
        tbl[4] = '{1'b0, 5'd0, 64'h0, 1'b1, 5'd0, 64'h9,  1'b1, 5'd7, 64'h77, 1'b0, 5'd0, 64'h0,  1'b1, 1'b0};
        tbl[5] = '{1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0,  1'b1, 5'd0, 64'h3,  1'b0, 5'd0, 64'h0,  1'b1, 1'b1};
        tbl[6] = '{1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0,  1'b0, 5'd0, 64'h0,  1'b0, 5'd0, 64'h0,  1'b1, 1'b1};

        idle_inputs();
        rs1 = 5'd1; rs2 = 5'd2;
        m_sb = '0; m_cnt = 0;
        rst = 1'b1;
        check_now(); tick();
        pipe_v = 1'b1; pipe_a = 5'd3; cfg_v = 1'b1; cfg_a = 5'd4; ll_v = 1'b1; ll_a = 5'd5;
        check_now();
        chk("reset_rd_w_v", {63'd0, rd_w_v}, 64'd0);
        tick();
        idle_inputs();
        rst = 1'b0;
        check_now();
        chk("post_reset_stall", {63'd0, stall}, 64'd0);
        tick();

`ifndef BP_BE_IRF_WB_SKID_EN
        for (int i = 0; i < 7; i++) begin
            pipe_v = tbl[i].pv; pipe_a = tbl[i].pa; pipe_d = tbl[i].pd;
            cfg_v  = tbl[i].cv; cfg_a  = tbl[i].ca; cfg_d  = tbl[i].cd;
            ll_v   = tbl[i].lv; ll_a   = tbl[i].la; ll_d   = tbl[i].ld;
            check_now();
            chk($sformatf("vec%0d_w_v", i), {63'd0, rd_w_v}, {63'd0, tbl[i].ew});
            if (tbl[i].ew) begin
                chk($sformatf("vec%0d_addr", i), {59'd0, rd_a}, {59'd0, tbl[i].ea});
                chk($sformatf("vec%0d_data", i), rd_d, tbl[i].ed);
            end
            chk($sformatf("vec%0d_cfg_ready", i), {63'd0, cfg_ready}, {63'd0, tbl[i].ecr});
            chk($sformatf("vec%0d_ll_ready", i), {63'd0, ll_rdy}, {63'd0, tbl[i].elr});
            tick();
        end
        idle_inputs();
`endif

        // Issue r9, retire it, watch the busy bit clear.
        idle_inputs(); rs1 = 5'd9;
        iss_v = 1'b1; iss_rd = 5'd9;
        check_now(); tick();
        idle_inputs(); ll_v = 1'b1; ll_a = 5'd9; ll_d = 64'h99;
        check_now();
        chk("t2_busy_set", {63'd0, rs1_busy}, 64'd1);
        tick();
        idle_inputs();
        check_now();
`ifndef BP_BE_IRF_WB_SKID_EN
        chk("t2_busy_clear", {63'd0, rs1_busy}, 64'd0);
`endif
        tick();
        check_now(); tick();

`ifndef BP_BE_IRF_WB_SKID_EN
        // Reissue r3 in the same cycle it retires.
        idle_inputs(); rs1 = 5'd3;
        iss_v = 1'b1; iss_rd = 5'd3;
        check_now(); tick();
        ll_v = 1'b1; ll_a = 5'd3; ll_d = 64'h33;
        check_now(); tick();
        idle_inputs();
        check_now();
        chk("t3_busy_kept", {63'd0, rs1_busy}, 64'd1);
        tick();
        ll_v = 1'b1; ll_a = 5'd3; ll_d = 64'h34;
        check_now(); tick();
        idle_inputs();
        check_now(); tick();
`endif

        // Starvation: ll blocked by pipe for 8 cycles.
        idle_inputs();
        for (int i = 0; i < 8; i++) begin
            pipe_v = 1'b1; pipe_a = 5'd1; pipe_d = 64'(i);
            ll_v = 1'b1; ll_a = 5'd7; ll_d = 64'h77;
            check_now();
`ifndef BP_BE_IRF_WB_SKID_EN
            chk($sformatf("t4_stall_low%0d", i), {63'd0, stall}, 64'd0);
`endif
            tick();
        end
        pipe_v = 1'b0;
        check_now();
`ifndef BP_BE_IRF_WB_SKID_EN
        chk("t4_stall_high", {63'd0, stall}, 64'd1);
        chk("t4_ll_write", {59'd0, rd_a}, 64'd7);
`endif
        tick();
        idle_inputs();
        check_now();
`ifndef BP_BE_IRF_WB_SKID_EN
        chk("t4_stall_drop", {63'd0, stall}, 64'd0);
`endif
        tick();
        check_now(); tick();

        // ll write to x0 with r2 pending.
        idle_inputs(); rs1 = 5'd2;
        iss_v = 1'b1; iss_rd = 5'd2;
        check_now(); tick();
        idle_inputs(); ll_v = 1'b1; ll_a = 5'd0; ll_d = 64'hDEAD;
        check_now();
        chk("t5_x0_ready", {63'd0, ll_rdy}, 64'd1);
        chk("t5_x0_no_write", {63'd0, rd_w_v}, 64'd0);
        tick();
        idle_inputs();
        check_now();
        chk("t5_sb_unchanged", {63'd0, rs1_busy}, 64'd1);
        tick();
        check_now(); tick();
        ll_v = 1'b1; ll_a = 5'd2; ll_d = 64'h22;
        check_now(); tick();
        idle_inputs();
        check_now(); tick();
        check_now(); tick();

`ifdef BP_BE_IRF_WB_SKID_EN
        // Reset with a full skid and a pending bit.
        idle_inputs(); rs1 = 5'd4;
        iss_v = 1'b1; iss_rd = 5'd4;
        check_now(); tick();
        idle_inputs(); pipe_v = 1'b1; pipe_a = 5'd1; ll_v = 1'b1; ll_a = 5'd4; ll_d = 64'h44;
        check_now(); tick();
        ll_v = 1'b0;
        check_now();
        chk("t6_skid_full", {63'd0, ll_rdy}, 64'd0);
        tick();
        rst = 1'b1;
        check_now(); tick();
        rst = 1'b0; idle_inputs();
        check_now();
        chk("t6_sb_cleared", {63'd0, rs1_busy}, 64'd0);
        chk("t6_no_write", {63'd0, rd_w_v}, 64'd0);
        chk("t6_skid_empty", {63'd0, ll_rdy}, 64'd1);
        tick();
`endif

        for (int i = 0; i < 400; i++) begin
            rst    = ($urandom_range(0, 99) == 0);
            pipe_v = ($urandom_range(0, 9) < 3);
            pipe_a = 5'($urandom_range(0, 7));
            pipe_d = {$urandom, $urandom};
            cfg_v  = ($urandom_range(0, 9) < 3);
            cfg_a  = 5'($urandom_range(0, 7));
            cfg_d  = {$urandom, $urandom};
            ll_v   = ($urandom_range(0, 9) < 5);
            ll_a   = 5'($urandom_range(0, 7));
            ll_d   = {$urandom, $urandom};
            iss_rd = 5'($urandom_range(0, 7));
            iss_v  = ($urandom_range(0, 9) < 3) && !m_sb[iss_rd];
            rs1    = 5'($urandom_range(0, 7));
            rs2    = 5'($urandom_range(0, 7));
            check_now();
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
